// File: rtl/led_display_hub75_driver_pkg.sv
// Shared types and constants for the HUB75 panel driver: row layout, pin bundle and FSM states.
package led_display_package;

    localparam int GL_NUM_COLS  = 64;
    localparam int GL_PIX_W     = 6;
    localparam int GL_RGB_ROW_W = GL_NUM_COLS * GL_PIX_W;

    typedef logic [GL_RGB_ROW_W-1:0] rgb_row_t;

    typedef struct packed {
        logic [2:0] rgb_top;
        logic [2:0] rgb_bot;
        logic       sclk;
        logic       latch;
        logic       n_oe;
        logic [3:0] addr;
    } hub75_pins_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } drv_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/led_display_hub75_driver_sclk_gen.sv
// Panel shift-clock generator: CLK_DIV cycles low then CLK_DIV high while enabled, parked low otherwise.
module led_display_sclk_gen
    import led_display_package::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_fall
);

    localparam int CNT_W = cnt_width(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_half_done;

    assign w_half_done = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign o_sclk      = r_sclk;
    assign o_fall      = i_en && w_half_done && r_sclk;

    // Half-period counter and sclk level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_sclk <= 1'b0;
        end else if (w_half_done) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_sclk <= r_sclk;
        end
    end

endmodule

// File: rtl/led_display_hub75_driver.sv
// HUB75 row driver: double-buffers one pixel row, shifts it out, then blanks, latches and lights the panel.
module led_display_hub75_driver
    import led_display_package::*;
#(
    parameter int NUM_COLS     = GL_NUM_COLS,
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int LATCH_CYCLES = 2,
    parameter int OE_ON_CYCLES = 1024
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  rgb_row_t   row_in,
    input  logic       row_valid_in,
    input  logic [3:0] row_address_in,
    output logic       row_ready_out,
    output logic [2:0] rgb_top_out,
    output logic [2:0] rgb_bot_out,
    output logic       sclk_out,
    output logic       latch_out,
    output logic       n_oe_out,
    output logic [3:0] addr_out,
    output logic       overrun_out
);

    localparam int ROW_W = $bits(rgb_row_t);
    localparam int COL_W = cnt_width(NUM_COLS);
    localparam int TMR_W = cnt_width(max3(BLANK_CYCLES, LATCH_CYCLES, OE_ON_CYCLES));

    drv_state_t       r_state;
    drv_state_t       w_state_nxt;
    rgb_row_t         r_shadow;
    logic [3:0]       r_shadow_addr;
    logic             r_shadow_full;
    rgb_row_t         r_shift;
    logic [3:0]       r_cur_addr;
    logic [COL_W-1:0] r_col;
    logic [TMR_W-1:0] r_timer;
    logic             r_latch;
    logic             r_n_oe;
    logic [3:0]       r_addr;
    logic             r_overrun;
    logic             w_latch_nxt;
    logic             w_n_oe_nxt;
    logic [3:0]       w_addr_nxt;
    logic             w_timer_done;
    logic             w_capture;
    logic             w_load;
    logic             w_sclk;
    logic             w_sclk_fall;
    hub75_pins_t      w_pins;

    assign w_capture     = row_valid_in && !r_shadow_full;
    assign w_load        = (r_state == ST_IDLE) && r_shadow_full;
    assign row_ready_out = !r_shadow_full;

    led_display_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk  (clk_in),
        .i_rst  (reset_in),
        .i_en   (r_state == ST_SHIFT),
        .o_sclk (w_sclk),
        .o_fall (w_sclk_fall)
    );

    // Shadow buffer capture/release and overrun flag
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_shadow      <= {ROW_W{1'b0}};
            r_shadow_addr <= 4'd0;
            r_shadow_full <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= row_valid_in && r_shadow_full;
            if (w_capture) begin
                r_shadow      <= row_in;
                r_shadow_addr <= row_address_in;
                r_shadow_full <= 1'b1;
            end else if (w_load) begin
                r_shadow_full <= 1'b0;
            end else begin
                r_shadow_full <= r_shadow_full;
            end
        end
    end

    // Column shift register; column 0 sits in the MSBs and moves out first
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_shift    <= {ROW_W{1'b0}};
            r_cur_addr <= 4'd0;
            r_col      <= {COL_W{1'b0}};
        end else if (w_load) begin
            r_shift    <= r_shadow;
            r_cur_addr <= r_shadow_addr;
            r_col      <= {COL_W{1'b0}};
        end else if (w_sclk_fall) begin
            r_shift <= r_shift << GL_PIX_W;
            r_col   <= (r_col == COL_W'(NUM_COLS - 1)) ? r_col : r_col + COL_W'(1);
        end else begin
            r_shift <= r_shift;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase timer terminal count
    always_comb begin
        w_timer_done = 1'b0;
        case (r_state)
            ST_BLANK:   w_timer_done = (r_timer == TMR_W'(BLANK_CYCLES - 1));
            ST_LATCH:   w_timer_done = (r_timer == TMR_W'(LATCH_CYCLES - 1));
            ST_DISPLAY: w_timer_done = (r_timer == TMR_W'(OE_ON_CYCLES - 1));
            default:    w_timer_done = 1'b0;
        endcase
    end

    // FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = w_load ? ST_SHIFT : ST_IDLE;
            ST_SHIFT:   w_state_nxt = (w_sclk_fall && (r_col == COL_W'(NUM_COLS - 1)))
                                      ? ST_BLANK : ST_SHIFT;
            ST_BLANK:   w_state_nxt = w_timer_done ? ST_LATCH : ST_BLANK;
            ST_LATCH:   w_state_nxt = w_timer_done ? ST_DISPLAY : ST_LATCH;
            ST_DISPLAY: w_state_nxt = w_timer_done ? ST_IDLE : ST_DISPLAY;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the pin registers line up with r_state
    always_comb begin
        w_latch_nxt = 1'b0;
        w_n_oe_nxt  = 1'b1;
        w_addr_nxt  = r_addr;
        case (w_state_nxt)
            ST_BLANK:   w_addr_nxt  = r_cur_addr;
            ST_LATCH:   w_latch_nxt = 1'b1;
            ST_DISPLAY: w_n_oe_nxt  = 1'b0;
            default:    w_latch_nxt = 1'b0;
        endcase
    end

    // Phase timer and registered panel controls; reset blanks the panel immediately
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_timer <= {TMR_W{1'b0}};
            r_latch <= 1'b0;
            r_n_oe  <= 1'b1;
            r_addr  <= 4'd0;
        end else begin
            r_latch <= w_latch_nxt;
            r_n_oe  <= w_n_oe_nxt;
            r_addr  <= w_addr_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= {TMR_W{1'b0}};
            end else if ((r_state == ST_BLANK) || (r_state == ST_LATCH) ||
                         (r_state == ST_DISPLAY)) begin
                r_timer <= r_timer + TMR_W'(1);
            end else begin
                r_timer <= {TMR_W{1'b0}};
            end
        end
    end

    always_comb begin
        w_pins.rgb_top = r_shift[ROW_W-1 -: 3];
        w_pins.rgb_bot = r_shift[ROW_W-4 -: 3];
        w_pins.sclk    = w_sclk;
        w_pins.latch   = r_latch;
        w_pins.n_oe    = r_n_oe;
        w_pins.addr    = r_addr;
    end

    assign rgb_top_out = w_pins.rgb_top;
    assign rgb_bot_out = w_pins.rgb_bot;
    assign sclk_out    = w_pins.sclk;
    assign latch_out   = w_pins.latch;
    assign n_oe_out    = w_pins.n_oe;
    assign addr_out    = w_pins.addr;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_led_display_hub75_driver.sv
// Bench for the HUB75 driver: frame-timeline model checked every cycle, plus per-frame literal checks.
module tb_led_display_hub75_driver;

    localparam int CD        = 2;
    localparam int NC        = 64;
    localparam int BL        = 4;
    localparam int LA        = 2;
    localparam int OE        = 1024;
    localparam int SHIFT_LEN = 2 * CD * NC;
    localparam int LATCH_AT  = SHIFT_LEN + BL;
    localparam int OE_AT     = LATCH_AT + LA;
    localparam int FRAME_LEN = OE_AT + OE;

    logic         clk_in = 1'b0;
    logic         reset_in = 1'b0;
    logic [383:0] row_in = '0;
    logic         row_valid_in = 1'b0;
    logic [3:0]   row_address_in = 4'd0;
    logic         row_ready_out;
    logic [2:0]   rgb_top_out;
    logic [2:0]   rgb_bot_out;
    logic         sclk_out;
    logic         latch_out;
    logic         n_oe_out;
    logic [3:0]   addr_out;
    logic         overrun_out;

    led_display_hub75_driver #(
        .NUM_COLS(NC), .CLK_DIV(CD), .BLANK_CYCLES(BL), .LATCH_CYCLES(LA), .OE_ON_CYCLES(OE)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .row_in(row_in), .row_valid_in(row_valid_in),
        .row_address_in(row_address_in), .row_ready_out(row_ready_out),
        .rgb_top_out(rgb_top_out), .rgb_bot_out(rgb_bot_out), .sclk_out(sclk_out),
        .latch_out(latch_out), .n_oe_out(n_oe_out), .addr_out(addr_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: a frame is a timeline of FRAME_LEN cycles counted from the load edge
    bit           m_busy = 1'b0;
    int           m_k = 0;
    bit           m_full = 1'b0;
    bit           m_ovr = 1'b0;
    logic [383:0] m_row = '0;
    logic [383:0] m_sh_row = '0;
    logic [3:0]   m_cur = 4'd0;
    logic [3:0]   m_sh_addr = 4'd0;
    logic [3:0]   m_addr_out = 4'd0;

    always @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            m_busy <= 1'b0; m_k <= 0; m_full <= 1'b0; m_ovr <= 1'b0; m_addr_out <= 4'd0;
        end else begin
            m_ovr <= row_valid_in && m_full;
            if (m_busy) begin
                m_k <= m_k + 1;
                if (m_k + 1 == SHIFT_LEN) m_addr_out <= m_cur;
                if (m_k + 1 == FRAME_LEN) m_busy <= 1'b0;
            end else if (m_full) begin
                m_busy <= 1'b1; m_k <= 0; m_row <= m_sh_row; m_cur <= m_sh_addr;
            end
            if (row_valid_in && !m_full) begin
                m_sh_row <= row_in; m_sh_addr <= row_address_in; m_full <= 1'b1;
            end else if (!m_busy && m_full) begin
                m_full <= 1'b0;
            end
        end
    end

    always @(negedge clk_in) begin : cmp_proc
        logic [5:0]  pix;
        logic [14:0] e_vec;
        logic [14:0] g_vec;
        bit          sh;
        if (started && !reset_in) begin
            sh    = m_busy && (m_k < SHIFT_LEN);
            pix   = sh ? m_row[383 - 6 * (m_k / (2 * CD)) -: 6] : 6'd0;
            e_vec = {!m_full, pix, sh && (((m_k / CD) % 2) == 1),
                     m_busy && (m_k >= LATCH_AT) && (m_k < OE_AT),
                     !(m_busy && (m_k >= OE_AT)), m_addr_out, m_ovr};
            g_vec = {row_ready_out, rgb_top_out, rgb_bot_out, sclk_out, latch_out,
                     n_oe_out, addr_out, overrun_out};
            check("outputs", 32'(g_vec), 32'(e_vec));
        end
    end

    // Per-frame observations of the panel pins
    int         cyc = 0;
    int         rise_cnt = 0;
    int         lat_w = 0;
    int         oe_w = 0;
    int         t_oe_rise = 0;
    bit         gap_armed = 1'b0;
    logic       p_sclk = 1'b0;
    logic       p_latch = 1'b0;
    logic       p_noe = 1'b1;
    logic [5:0] first_pix = 6'd0;
    logic [5:0] last_pix = 6'd0;
    int         q_rises[$];
    int         q_latw[$];
    int         q_oew[$];
    int         q_gap[$];
    logic [5:0] q_first[$];
    logic [5:0] q_last[$];
    logic [3:0] q_addr[$];

    always @(negedge clk_in) begin
        cyc++;
        if (reset_in) begin
            rise_cnt = 0; lat_w = 0; oe_w = 0; gap_armed = 1'b0;
            p_sclk = 1'b0; p_latch = 1'b0; p_noe = 1'b1;
        end else begin
            if (sclk_out && !p_sclk) begin
                if (rise_cnt == 0) first_pix = {rgb_top_out, rgb_bot_out};
                last_pix = {rgb_top_out, rgb_bot_out};
                rise_cnt++;
                if (gap_armed) begin
                    q_gap.push_back(cyc - t_oe_rise);
                    gap_armed = 1'b0;
                end
            end
            if (latch_out && !p_latch) begin
                q_rises.push_back(rise_cnt); q_first.push_back(first_pix);
                q_last.push_back(last_pix); q_addr.push_back(addr_out);
                rise_cnt = 0;
            end
            if (latch_out) begin
                check("latch_with_noe_high", 32'(n_oe_out), 32'd1);
                lat_w++;
            end else if (p_latch) begin
                q_latw.push_back(lat_w); lat_w = 0;
            end
            if (!n_oe_out) begin
                oe_w++;
            end else if (!p_noe) begin
                q_oew.push_back(oe_w); oe_w = 0; t_oe_rise = cyc; gap_armed = 1'b1;
            end
            p_sclk = sclk_out; p_latch = latch_out; p_noe = n_oe_out;
        end
    end

    function automatic logic [383:0] rand_row();
        logic [383:0] r;
        for (int w = 0; w < 12; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!row_ready_out && n < budget) begin @(negedge clk_in); n++; end
        if (n >= budget) check("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_model_k(input int k, input int budget);
        int n = 0;
        while (!(m_busy && m_k == k) && n < budget) begin @(negedge clk_in); n++; end
        if (n >= budget) check("wait_k_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || m_full || !row_ready_out) && n < budget) begin
            @(negedge clk_in); n++;
        end
        if (n >= budget) check("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_row(input logic [383:0] r, input logic [3:0] a);
        wait_ready(4000);
        row_in = r; row_address_in = a; row_valid_in = 1'b1;
        @(negedge clk_in);
        row_valid_in = 1'b0;
    endtask

    task automatic check_reset_pins();
        check("rst_ready", 32'(row_ready_out), 32'd1);
        check("rst_noe", 32'(n_oe_out), 32'd1);
        check("rst_sclk", 32'(sclk_out), 32'd0);
        check("rst_latch", 32'(latch_out), 32'd0);
        check("rst_addr", 32'(addr_out), 32'd0);
        check("rst_rgb", 32'({rgb_top_out, rgb_bot_out}), 32'd0);
        check("rst_overrun", 32'(overrun_out), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [383:0] ra;
        // reset and idle
        #1 reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check_reset_pins();
        reset_in = 1'b0;
        started  = 1'b1;
        repeat (20) @(negedge clk_in);
        check("idle_noe", 32'(n_oe_out), 32'd1);
        check("idle_ready", 32'(row_ready_out), 32'd1);
        check("idle_sclk", 32'(sclk_out), 32'd0);

        // first row, second row during its display, third row while the shadow is full
        ra = rand_row();
        ra[383:378] = 6'b101_010;
        ra[5:0]     = 6'b111_000;
        send_row(ra, 4'd5);
        wait_model_k(600, 4000);
        send_row(rand_row(), 4'd10);
        check("ready_drop", 32'(row_ready_out), 32'd0);
        row_in = rand_row(); row_address_in = 4'd3; row_valid_in = 1'b1;
        @(negedge clk_in);
        row_valid_in = 1'b0;
        check("overrun_pulse", 32'(overrun_out), 32'd1);
        @(negedge clk_in);
        check("overrun_once", 32'(overrun_out), 32'd0);
        wait_idle(5000);
        repeat (10) @(negedge clk_in);
        check("frames_after_overrun", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() >= 2) begin
            check("a_sclk_rises", 32'(q_rises[0]), 32'd64);
            check("a_first_pixel", 32'(q_first[0]), 32'h2A);
            check("a_last_pixel", 32'(q_last[0]), 32'h38);
            check("a_addr_at_latch", 32'(q_addr[0]), 32'd5);
            check("b_addr_at_latch", 32'(q_addr[1]), 32'd10);
            check("b_sclk_rises", 32'(q_rises[1]), 32'd64);
        end
        if (q_latw.size() >= 1) check("a_latch_width", 32'(q_latw[0]), 32'd2);
        if (q_oew.size() >= 1) check("a_oe_low_width", 32'(q_oew[0]), 32'd1024);
        if (q_gap.size() >= 1) check("idle_to_first_rise", 32'(q_gap[0]), 32'd3);

        // back-to-back addresses 0..15 then wrap to 0
        for (int i = 0; i < 17; i++) send_row(rand_row(), 4'(i % 16));
        wait_idle(5000);
        repeat (10) @(negedge clk_in);
        check("frames_after_sweep", 32'(q_addr.size()), 32'd19);
        if (q_addr.size() >= 19) begin
            for (int i = 0; i < 17; i++) check("sweep_addr", 32'(q_addr[2 + i]), 32'(i % 16));
        end

        // reset in the middle of column 20
        send_row(rand_row(), 4'd9);
        wait_model_k(20 * 2 * CD, 4000);
        #1 reset_in = 1'b1;
        #1 check_reset_pins();
        @(negedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b0;
        check("ready_after_rst", 32'(row_ready_out), 32'd1);
        repeat (1500) @(negedge clk_in);
        check("aborted_row_not_latched", 32'(q_addr.size()), 32'd19);
        check("final_noe", 32'(n_oe_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
